// File: rtl/md_unit.sv
// Iterative multiply/divide unit with architectural HI/LO for the multi-cycle MIPS EX step.
// Optional build macro MD_UNIT_EARLY_OUT_EN lets multiplies finish once the multiplier is exhausted.
module md_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // acc: product accumulator (mult) or partial remainder in the low half (div)
  logic [W2-1:0]      acc_q, acc_d;
  // opa: left-shifting multiplicand (mult) or divisor in the low half (div)
  logic [W2-1:0]      opa_q, opa_d;
  // opb: right-shifting multiplier (mult) or dividend shifting into quotient (div)
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dbz_q, dbz_d;
  logic               dbz_out_q, dbz_out_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               op_signed;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     shift_rem;
  logic [WIDTH-1:0]   rem_diff;
  logic               rem_ge;
  logic [W2-1:0]      prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               early_out;

  assign op_signed = ~op[0];
  assign a_abs     = (op_signed && A[WIDTH-1]) ? -A : A;
  assign b_abs     = (op_signed && B[WIDTH-1]) ? -B : B;

  // Restoring step: bring in the next dividend bit, subtract only if it fits.
  assign shift_rem = {acc_q[WIDTH-1:0], opb_q[WIDTH-1]};
  assign rem_ge    = shift_rem >= {1'b0, opa_q[WIDTH-1:0]};
  assign rem_diff  = shift_rem[WIDTH-1:0] - opa_q[WIDTH-1:0];

  assign prod_fix  = neg_q  ? -acc_q             : acc_q;
  assign quo_fix   = neg_q  ? -opb_q             : opb_q;
  assign rem_fix   = rneg_q ? -acc_q[WIDTH-1:0]  : acc_q[WIDTH-1:0];

`ifdef MD_UNIT_EARLY_OUT_EN
  assign early_out = !is_div_q && (opb_q == '0);
`else
  assign early_out = 1'b0;
`endif

  always_comb begin
    // NOTE: every _d gets a hold default first so no path through the case infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    dbz_d     = dbz_q;
    dbz_out_d = dbz_out_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          acc_d     = '0;
          is_div_d  = op[1];
          neg_d     = op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
          rneg_d    = op_signed && A[WIDTH-1];
          dbz_d     = op[1] && (B == '0);
          dbz_out_d = 1'b0;
          if (op[1]) begin
            opa_d = {{WIDTH{1'b0}}, b_abs};
            opb_d = a_abs;
          end else begin
            opa_d = {{WIDTH{1'b0}}, a_abs};
            opb_d = b_abs;
          end
        end else begin
          if (hi_we) hi_d = A;
          if (lo_we) lo_d = A;
        end
      end

      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          if (dbz_q) begin
            state_d = S_FINISH;
          end else begin
            opb_d = {opb_q[WIDTH-2:0], rem_ge};
            acc_d = {{WIDTH{1'b0}}, rem_ge ? rem_diff : shift_rem[WIDTH-1:0]};
            if (cnt_q == '1) state_d = S_FINISH;
          end
        end else if (early_out) begin
          state_d = S_FINISH;
        end else begin
          if (opb_q[0]) acc_d = acc_q + opa_q;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
          if (cnt_q == '1) state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        state_d   = S_IDLE;
        done_d    = 1'b1;
        dbz_out_d = dbz_q;
        if (!dbz_q) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[W2-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state registers use non-blocking assignment so every flop sees pre-edge values.
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dbz_q     <= 1'b0;
      dbz_out_q <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      dbz_q     <= dbz_d;
      dbz_out_q <= dbz_out_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_out_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: transaction-level HI/LO model compared every cycle,
// directed corner cases with literal expectations, then randomized traffic.
module tb_md_unit;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        hi_we, lo_we;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  md_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural state plus a countdown to the commit edge.
  logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
  bit          m_busy = 0, m_done = 0, m_dbz = 0, r_dbz = 0;
  int          m_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mult_latency(input logic [1:0] o, input logic [31:0] b);
`ifdef MD_UNIT_EARLY_OUT_EN
    logic [31:0] m;
    int k;
    m = (!o[0] && b[31]) ? -b : b;
    k = 0;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
    return (k + 2 > 33) ? 33 : k + 2;
`else
    return 33;
`endif
  endfunction

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_dbz = 0; m_left = 0;
  endtask

  task automatic model_step();
    longint sa, sb, q, r;
    logic [63:0] p;
    m_done = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_done = 1;
        m_dbz  = r_dbz;
        if (!r_dbz) begin
          m_hi = r_hi;
          m_lo = r_lo;
        end
      end
    end else if (start) begin
      sa = longint'($signed(A));
      sb = longint'($signed(B));
      r_dbz = 0;
      case (op)
        2'b00: begin p = 64'(sa * sb); r_hi = p[63:32]; r_lo = p[31:0]; m_left = mult_latency(op, B); end
        2'b01: begin p = {32'b0, A} * {32'b0, B}; r_hi = p[63:32]; r_lo = p[31:0]; m_left = mult_latency(op, B); end
        default: begin
          if (B == 0) begin
            r_dbz = 1; m_left = 2;
          end else begin
            m_left = 33;
            if (op == 2'b10) begin
              q = sa / sb; r = sa % sb;
              r_lo = q[31:0]; r_hi = r[31:0];
            end else begin
              r_lo = A / B; r_hi = A % B;
            end
          end
        end
      endcase
      m_busy = 1;
      m_dbz  = 0;
    end else begin
      if (hi_we) m_hi = A;
      if (lo_we) m_lo = A;
    end
  endtask

  // One clock: the model follows the same edge the DUT sees, then outputs settle for the compare.
  task automatic step();
    @(posedge clk);
    if (rstn) model_step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'b0, busy}, {31'b0, m_busy});
      check("done", {31'b0, done}, {31'b0, m_done});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      if (m_done) check("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_dbz});
    end
  end

  task automatic clear_inputs();
    start = 0; hi_we = 0; lo_we = 0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int nbusy);
    op = o; A = a; B = b; start = 1;
    step();
    clear_inputs();
    nbusy = busy ? 1 : 0;
    for (int i = 0; i < 40 && !m_done; i++) begin
      step();
      if (busy) nbusy++;
    end
    check("op_completes", {31'b0, done}, 32'd1);
  endtask

  int nb;

  initial begin
    rstn = 0; clear_inputs(); op = 0; A = 0; B = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    #2 rstn = 1;
    model_reset();
    chk_en = 1;
    @(negedge clk);

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, nb);
    check("multu_max_hi", hi, 32'hFFFFFFFE);
    check("multu_max_lo", lo, 32'h00000001);
    check("multu_max_busy_cycles", nb, 33);

    run_op(2'b00, 32'hFFFFFFFD, 32'd7, nb);
    check("mult_neg_hi", hi, 32'hFFFFFFFF);
    check("mult_neg_lo", lo, 32'hFFFFFFEB);

    run_op(2'b10, 32'hFFFFFFF9, 32'd2, nb);
    check("div_neg_lo", lo, 32'hFFFFFFFD);
    check("div_neg_hi", hi, 32'hFFFFFFFF);

    run_op(2'b11, 32'd100, 32'd7, nb);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    run_op(2'b10, 32'd5, 32'd0, nb);
    check("dbz_flag", {31'b0, div_by_zero}, 32'd1);
    check("dbz_busy_cycles", nb, 2);
    check("dbz_hi_kept", hi, 32'd2);
    check("dbz_lo_kept", lo, 32'd14);

    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, nb);
    check("div_ovf_lo", lo, 32'h80000000);
    check("div_ovf_hi", hi, 32'd0);
    check("div_ovf_dbz", {31'b0, div_by_zero}, 32'd0);

    // New start and mthi while busy must not disturb the running multiply.
    op = 2'b01; A = 32'h1234; B = 32'h5678; start = 1;
    step();
    clear_inputs();
    for (int i = 0; i < 9; i++) step();
    op = 2'b10; A = 32'hDEAD; B = 32'h3; start = 1; hi_we = 1;
    step();
    clear_inputs();
    for (int i = 0; i < 40 && !m_done; i++) step();
    check("busy_ignore_lo", lo, 32'h06260060);
    check("busy_ignore_hi", hi, 32'd0);

    A = 32'h12345678; lo_we = 1;
    step();
    clear_inputs();
    check("mtlo", lo, 32'h12345678);
    A = 32'hCAFEF00D; hi_we = 1;
    step();
    clear_inputs();
    check("mthi", hi, 32'hCAFEF00D);
    A = 32'h0BADBEEF; hi_we = 1; lo_we = 1;
    step();
    clear_inputs();
    check("mthilo_hi", hi, 32'h0BADBEEF);
    check("mthilo_lo", lo, 32'h0BADBEEF);
    lo_we = 1;
    run_op(2'b01, 32'd2, 32'd3, nb);
    check("start_beats_lo_we", lo, 32'd6);

    // Asynchronous reset in the middle of a divide.
    op = 2'b10; A = 32'd1000; B = 32'd3; start = 1;
    step();
    clear_inputs();
    for (int i = 0; i < 14; i++) step();
    #2 rstn = 0;
    model_reset();
    #1;
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_done", {31'b0, done}, 32'd0);
    check("async_rst_hi", hi, 32'd0);
    check("async_rst_lo", lo, 32'd0);
    step();
    #2 rstn = 1;
    @(negedge clk);
    run_op(2'b01, 32'd3, 32'd4, nb);
    check("post_rst_lo", lo, 32'd12);

    run_op(2'b01, 32'd9, 32'd0, nb);
    check("mul_zero_hi", hi, 32'd0);
    check("mul_zero_lo", lo, 32'd0);
`ifdef MD_UNIT_EARLY_OUT_EN
    check("mul_zero_busy_cycles", nb, 2);
`else
    check("mul_zero_busy_cycles", nb, 33);
`endif
    run_op(2'b01, 32'd9, 32'd1, nb);
    check("mul_one_lo", lo, 32'd9);
`ifdef MD_UNIT_EARLY_OUT_EN
    check("mul_one_busy_cycles", nb, 3);
`else
    check("mul_one_busy_cycles", nb, 33);
`endif

    // Random traffic: starts land both in idle and while busy, mthi/mtlo sprinkled throughout.
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       A = 32'h80000000;
        1:       A = 32'hFFFFFFFF;
        default: A = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       B = 32'd0;
        1:       B = 32'hFFFFFFFF;
        2:       B = 32'($urandom_range(0, 15));
        default: B = $urandom;
      endcase
      hi_we = ($urandom_range(0, 7) == 0);
      lo_we = ($urandom_range(0, 7) == 0);
      step();
    end
    clear_inputs();
    for (int i = 0; i < 40 && m_busy; i++) step();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
